// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared types, select codes and default timing for the VGA raster sequencer
//   phase_e    : axis phase (visible, front porch, sync, back porch)
//   axis_len_t : the four phase lengths of one axis
//   SEL_*      : cfg_sel codes, H registers 0..3, V registers 4..7
package vga_timing_pkg;

   localparam int LEN_W = 11;

   typedef enum logic [1:0] {
      PH_VIS  = 2'd0,
      PH_FP   = 2'd1,
      PH_SYNC = 2'd2,
      PH_BP   = 2'd3
   } phase_e;

   localparam logic [2:0] SEL_H_VIS = 3'd0;
   localparam logic [2:0] SEL_H_FP  = 3'd1;
   localparam logic [2:0] SEL_H_SW  = 3'd2;
   localparam logic [2:0] SEL_H_BP  = 3'd3;
   localparam logic [2:0] SEL_V_VIS = 3'd4;
   localparam logic [2:0] SEL_V_FP  = 3'd5;
   localparam logic [2:0] SEL_V_SW  = 3'd6;
   localparam logic [2:0] SEL_V_BP  = 3'd7;

   localparam int DEF_H_VIS = 800;
   localparam int DEF_H_FP  = 56;
   localparam int DEF_H_SW  = 120;
   localparam int DEF_H_BP  = 64;
   localparam int DEF_V_VIS = 600;
   localparam int DEF_V_FP  = 37;
   localparam int DEF_V_SW  = 6;
   localparam int DEF_V_BP  = 23;

   typedef struct packed {
      logic [LEN_W-1:0] vis;
      logic [LEN_W-1:0] fp;
      logic [LEN_W-1:0] sw;
      logic [LEN_W-1:0] bp;
   } axis_len_t;

   // A zero-length phase would stall the axis, so zero is stored as one.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] val);
      return (val == '0) ? LEN_W'(1) : val;
   endfunction

   function automatic axis_len_t set_len(input axis_len_t cur, input logic [1:0] idx,
                                         input logic [LEN_W-1:0] val);
      axis_len_t res;
      res = cur;
      case (idx)
         2'd0:    res.vis = val;
         2'd1:    res.fp  = val;
         2'd2:    res.sw  = val;
         default: res.bp  = val;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/vga_timing_ctrl_axis.sv
// rtl/vga_timing_ctrl_axis.sv - one raster axis: VIS -> FP -> SYNC -> BP phase sequencer
//   sys_clk, rst : pixel clock, async active-high reset
//   adv          : advance one count this clock
//   len          : lengths of the four phases (each >= 1)
//   phase_nxt    : phase the axis holds after this edge
//   cnt_nxt      : phase counter after this edge
//   wrap         : current clock is the last count of PH_BP
module vga_axis_seq
   import vga_timing_pkg::*;
(
   input  logic             sys_clk,
   input  logic             rst,
   input  logic             adv,
   input  axis_len_t        len,
   output phase_e           phase_nxt,
   output logic [LEN_W-1:0] cnt_nxt,
   output logic             wrap
);

   phase_e           phase;
   logic [LEN_W-1:0] cnt;
   logic [LEN_W-1:0] cur_len;
   logic             last;

   always_comb begin
      cur_len = len.vis;
      case (phase)
         PH_VIS:  cur_len = len.vis;
         PH_FP:   cur_len = len.fp;
         PH_SYNC: cur_len = len.sw;
         PH_BP:   cur_len = len.bp;
         default: cur_len = len.vis;
      endcase
   end

   // >= rather than == keeps the counter bounded even if lengths shrink.
   assign last = (cnt >= cur_len - LEN_W'(1));
   assign wrap = (phase == PH_BP) && last;

   // Next state is exported so the top can register outputs aligned with the state.
   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt;
      if (adv) begin
         if (last) begin
            cnt_nxt = '0;
            case (phase)
               PH_VIS:  phase_nxt = PH_FP;
               PH_FP:   phase_nxt = PH_SYNC;
               PH_SYNC: phase_nxt = PH_BP;
               default: phase_nxt = PH_VIS;
            endcase
         end else begin
            cnt_nxt = cnt + LEN_W'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         phase <= PH_VIS;
         cnt   <= '0;
      end else begin
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
      end
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// rtl/vga_timing_ctrl.sv - programmable VGA raster sequencer with frame-boundary commit
//   sys_clk, rst            : pixel clock, async active-high reset
//   cfg_we/cfg_sel/cfg_data : write one shadow timing register (ignored while busy)
//   cfg_commit              : apply shadow timing at the next frame end
//   cfg_busy, commit_done   : commit pending / new timing took effect
//   hsync, vsync            : active-low syncs
//   blank, px_x, px_y       : blanking and pixel coordinates
//   line_start, frame_start : first visible clock of a line / pixel (0,0)
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int CW    = LEN_W,
   parameter int H_VIS = DEF_H_VIS,
   parameter int H_FP  = DEF_H_FP,
   parameter int H_SW  = DEF_H_SW,
   parameter int H_BP  = DEF_H_BP,
   parameter int V_VIS = DEF_V_VIS,
   parameter int V_FP  = DEF_V_FP,
   parameter int V_SW  = DEF_V_SW,
   parameter int V_BP  = DEF_V_BP
) (
   input  logic          sys_clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic [2:0]    cfg_sel,
   input  logic [CW-1:0] cfg_data,
   input  logic          cfg_commit,
   output logic          cfg_busy,
   output logic          commit_done,
   output logic          hsync,
   output logic          vsync,
   output logic          blank,
   output logic [CW-1:0] px_x,
   output logic [CW-1:0] px_y,
   output logic          line_start,
   output logic          frame_start
);

   localparam axis_len_t DEF_H = '{vis: LEN_W'(H_VIS), fp: LEN_W'(H_FP),
                                   sw: LEN_W'(H_SW), bp: LEN_W'(H_BP)};
   localparam axis_len_t DEF_V = '{vis: LEN_W'(V_VIS), fp: LEN_W'(V_FP),
                                   sw: LEN_W'(V_SW), bp: LEN_W'(V_BP)};

   axis_len_t        shadow_h, shadow_v;
   axis_len_t        active_h, active_v;
   phase_e           h_ph_nxt, v_ph_nxt;
   logic [LEN_W-1:0] h_cnt_nxt, v_cnt_nxt;
   logic             h_wrap, v_wrap;
   logic             frame_end;
   logic             line_start_nxt;

   vga_axis_seq u_h_axis (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .adv       (1'b1),
      .len       (active_h),
      .phase_nxt (h_ph_nxt),
      .cnt_nxt   (h_cnt_nxt),
      .wrap      (h_wrap)
   );

   vga_axis_seq u_v_axis (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .adv       (h_wrap),
      .len       (active_v),
      .phase_nxt (v_ph_nxt),
      .cnt_nxt   (v_cnt_nxt),
      .wrap      (v_wrap)
   );

   // Last clock of the last line of vertical back porch.
   assign frame_end = h_wrap && v_wrap;

   // Active lengths only change on the frame-end edge, when both axes return
   // to (PH_VIS, 0), so the next frame starts cleanly under the new timing.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         shadow_h    <= DEF_H;
         shadow_v    <= DEF_V;
         active_h    <= DEF_H;
         active_v    <= DEF_V;
         cfg_busy    <= 1'b0;
         commit_done <= 1'b0;
      end else begin
         commit_done <= 1'b0;
         if (frame_end && (cfg_busy || cfg_commit)) begin
            active_h    <= shadow_h;
            active_v    <= shadow_v;
            cfg_busy    <= 1'b0;
            commit_done <= 1'b1;
         end else if (!cfg_busy && cfg_commit) begin
            cfg_busy <= 1'b1;
         end
         if (!cfg_busy && cfg_we) begin
            if (cfg_sel >= SEL_V_VIS)
               shadow_v <= set_len(shadow_v, cfg_sel[1:0], clamp_len(cfg_data));
            else
               shadow_h <= set_len(shadow_h, cfg_sel[1:0], clamp_len(cfg_data));
         end
      end
   end

   assign line_start_nxt = (h_ph_nxt == PH_VIS) && (h_cnt_nxt == '0);

   // Outputs are registered from the axes' next state, so they line up with the state registers.
   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         blank       <= 1'b0;
         px_x        <= '0;
         px_y        <= '0;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
      end else begin
         hsync       <= (h_ph_nxt != PH_SYNC);
         vsync       <= (v_ph_nxt != PH_SYNC);
         blank       <= (h_ph_nxt != PH_VIS) || (v_ph_nxt != PH_VIS);
         px_x        <= h_cnt_nxt;
         if (v_ph_nxt == PH_VIS)
            px_y <= v_cnt_nxt;
         line_start  <= line_start_nxt;
         frame_start <= line_start_nxt && (v_ph_nxt == PH_VIS) && (v_cnt_nxt == '0);
      end
   end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb/tb_vga_timing_ctrl.sv - scoreboard bench for vga_timing_ctrl
module tb_vga_timing_ctrl;

   localparam int BH_VIS = 40, BH_FP = 6, BH_SW = 8, BH_BP = 6;
   localparam int BV_VIS = 30, BV_FP = 3, BV_SW = 2, BV_BP = 4;
   localparam int LINE  = BH_VIS + BH_FP + BH_SW + BH_BP;
   localparam int FRAME = LINE * (BV_VIS + BV_FP + BV_SW + BV_BP);

   logic        sys_clk = 1'b0;
   logic        rst, cfg_we, cfg_commit;
   logic [2:0]  cfg_sel;
   logic [10:0] cfg_data;
   logic        cfg_busy, commit_done, hsync, vsync, blank, line_start, frame_start;
   logic [10:0] px_x, px_y;

   always #5 sys_clk = ~sys_clk;

   vga_timing_ctrl #(
      .CW(11), .H_VIS(BH_VIS), .H_FP(BH_FP), .H_SW(BH_SW), .H_BP(BH_BP),
      .V_VIS(BV_VIS), .V_FP(BV_FP), .V_SW(BV_SW), .V_BP(BV_BP)
   ) dut (
      .sys_clk(sys_clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
      .commit_done(commit_done), .hsync(hsync), .vsync(vsync), .blank(blank),
      .px_x(px_x), .px_y(px_y), .line_start(line_start), .frame_start(frame_start)
   );

   typedef struct packed {
      logic        hs, vs, bl;
      logic [10:0] x, y;
      logic        ls, fs, busy, done, xv;
   } vec_t;

   vec_t exp_q[$];
   int   vecs = 0, errs = 0;

   // reference raster: absolute position inside line/frame plus timing tables
   int th[4], tv[4], sh_h[4], sh_v[4];
   int mx, my, py;
   bit mbusy, mdone;

   // observed-output measurements
   int cyc, ls_last, fs_last, xcnt, yc, lp, fp, hfx, hlw, vfl, vlw, hs_t0, vs_t0;
   bit prev_hs, prev_vs, ev_hr, ev_vr;

   function automatic int hsum_m();
      return th[0] + th[1] + th[2] + th[3];
   endfunction

   function automatic int vsum_m();
      return tv[0] + tv[1] + tv[2] + tv[3];
   endfunction

   task automatic model_reset();
      th = '{BH_VIS, BH_FP, BH_SW, BH_BP};
      tv = '{BV_VIS, BV_FP, BV_SW, BV_BP};
      sh_h = th;
      sh_v = tv;
      mx = 0; my = 0; py = 0; mbusy = 0; mdone = 0;
   endtask

   task automatic meas_reset();
      cyc = 0; ls_last = 0; fs_last = 0; xcnt = 0; yc = 0;
      prev_hs = 1; prev_vs = 1;
   endtask

   function automatic vec_t model_vec();
      vec_t v;
      int   h01, v01;
      h01    = th[0] + th[1];
      v01    = tv[0] + tv[1];
      v.hs   = !(mx >= h01 && mx < h01 + th[2]);
      v.vs   = !(my >= v01 && my < v01 + tv[2]);
      v.bl   = !(mx < th[0] && my < tv[0]);
      v.xv   = (mx < th[0]);
      v.x    = v.xv ? 11'(mx) : 11'd0;
      v.y    = 11'(py);
      v.ls   = (mx == 0);
      v.fs   = (mx == 0 && my == 0);
      v.busy = mbusy;
      v.done = mdone;
      return v;
   endfunction

   function automatic vec_t dut_vec(input vec_t e);
      vec_t a;
      a.hs = hsync; a.vs = vsync; a.bl = blank;
      a.x  = e.xv ? px_x : 11'd0;
      a.y  = px_y; a.ls = line_start; a.fs = frame_start;
      a.busy = cfg_busy; a.done = commit_done; a.xv = e.xv;
      return a;
   endfunction

   task automatic model_step(input bit we, input int sel, input int data, input bit commit);
      int hs, vs, wv;
      bit fe, wr;
      hs = hsum_m();
      vs = vsum_m();
      fe = (mx == hs - 1) && (my == vs - 1);
      wr = we && !mbusy;
      mdone = 0;
      if (fe && (mbusy || commit)) begin
         th = sh_h; tv = sh_v; mbusy = 0; mdone = 1;
      end else if (!mbusy && commit) begin
         mbusy = 1;
      end
      if (wr) begin
         wv = (data == 0) ? 1 : data;
         if (sel < 4) sh_h[sel] = wv;
         else         sh_v[sel-4] = wv;
      end
      mx++;
      if (mx == hs) begin
         mx = 0;
         my++;
         if (my == vs) my = 0;
      end
      if (my < tv[0]) py = my;
   endtask

   task automatic tick(input bit we, input int sel, input int data, input bit commit);
      cfg_we = we; cfg_sel = 3'(sel); cfg_data = 11'(data); cfg_commit = commit;
      @(posedge sys_clk);
      model_step(we, sel, data, commit);
      exp_q.push_back(model_vec());
      @(negedge sys_clk);
      cfg_we = 0; cfg_commit = 0;
      cyc++; ev_hr = 0; ev_vr = 0;
      if (frame_start) begin fp = cyc - fs_last; fs_last = cyc; yc = 0; end
      else if (line_start) yc++;
      if (line_start) begin lp = cyc - ls_last; ls_last = cyc; xcnt = 0; end
      else xcnt++;
      if (prev_hs && !hsync) begin hfx = xcnt; hs_t0 = cyc; end
      if (!prev_hs && hsync) begin hlw = cyc - hs_t0; ev_hr = 1; end
      if (prev_vs && !vsync) begin vfl = yc; vs_t0 = cyc; end
      if (!prev_vs && vsync) begin vlw = cyc - vs_t0; ev_vr = 1; end
      prev_hs = hsync; prev_vs = vsync;
   endtask

   task automatic test_reset();
      vec_t e, a;
      rst = 1; cfg_we = 0; cfg_commit = 0; cfg_sel = 0; cfg_data = 0;
      repeat (3) @(negedge sys_clk);
      model_reset();
      meas_reset();
      exp_q.push_back(model_vec());
      e = exp_q.pop_front(); a = dut_vec(e); vecs++;
      if (a !== e) begin errs++; $display("FAIL reset_state got %h exp %h", a, e); end
      rst = 0;
      tick(0, 0, 0, 0);
      e = exp_q.pop_front(); a = dut_vec(e); vecs++;
      if (a !== e) begin errs++; $display("FAIL first_edge got %h exp %h", a, e); end
      vecs++;
      if (px_x !== 11'd1) begin errs++; $display("FAIL first_edge_px_x got %0d exp 1", px_x); end
   endtask

   task automatic test_default_timing();
      vec_t e, a;
      for (int i = 0; i < 2 * FRAME; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL default_raster cyc=%0d got %h exp %h", cyc, a, e); end
         if (line_start) begin
            vecs++;
            if (lp !== LINE) begin errs++; $display("FAIL line_period got %0d exp %0d", lp, LINE); end
         end
         if (frame_start) begin
            vecs++;
            if (fp !== FRAME) begin errs++; $display("FAIL frame_period got %0d exp %0d", fp, FRAME); end
         end
         if (ev_hr) begin
            vecs++;
            if (hfx !== BH_VIS + BH_FP || hlw !== BH_SW) begin
               errs++; $display("FAIL hsync_window got start %0d width %0d exp %0d %0d", hfx, hlw, BH_VIS + BH_FP, BH_SW);
            end
         end
         if (ev_vr) begin
            vecs++;
            if (vfl !== BV_VIS + BV_FP || vlw !== BV_SW * LINE) begin
               errs++; $display("FAIL vsync_window got line %0d width %0d exp %0d %0d", vfl, vlw, BV_VIS + BV_FP, BV_SW * LINE);
            end
         end
      end
   endtask

   task automatic test_blank_coords();
      vec_t e, a;
      int maxx = 0, maxy = 0, nls = 0;
      bit eb;
      for (int i = 0; i < FRAME; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL coord_raster cyc=%0d got %h exp %h", cyc, a, e); end
         eb = !(xcnt < BH_VIS && yc < BV_VIS);
         vecs++;
         if (blank !== eb) begin errs++; $display("FAIL blank_window x=%0d y=%0d got %b exp %b", xcnt, yc, blank, eb); end
         if (!blank) begin
            if (int'(px_x) > maxx) maxx = int'(px_x);
            if (int'(px_y) > maxy) maxy = int'(px_y);
         end
         if (line_start) nls++;
      end
      vecs++;
      if (maxx !== BH_VIS - 1 || maxy !== BV_VIS - 1) begin
         errs++; $display("FAIL coord_range got %0d,%0d exp %0d,%0d", maxx, maxy, BH_VIS - 1, BV_VIS - 1);
      end
      vecs++;
      if (nls !== FRAME / LINE) begin errs++; $display("FAIL line_start_count got %0d exp %0d", nls, FRAME / LINE); end
   endtask

   task automatic test_reprogram();
      vec_t e, a;
      int   tiny[8] = '{4, 1, 2, 1, 3, 1, 1, 1};
      bit   got = 0;
      for (int i = 0; i < 300; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL pre_write cyc=%0d got %h exp %h", cyc, a, e); end
      end
      for (int i = 0; i < 9; i++) begin
         if (i < 8) tick(1, i, tiny[i], 0);
         else       tick(0, 0, 0, 1);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL write_commit step=%0d got %h exp %h", i, a, e); end
      end
      vecs++;
      if (cfg_busy !== 1'b1) begin errs++; $display("FAIL busy_after_commit got %b exp 1", cfg_busy); end
      for (int i = 0; i < 2 * FRAME && !got; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL commit_wait cyc=%0d got %h exp %h", cyc, a, e); end
         if (commit_done) got = 1;
         else if (cfg_busy !== 1'b1) begin errs++; vecs++; $display("FAIL busy_held got %b exp 1", cfg_busy); end
      end
      vecs++;
      if (!got) begin errs++; $display("FAIL commit_timeout got no commit_done exp pulse"); end
      vecs++;
      if (frame_start !== 1'b1) begin errs++; $display("FAIL done_at_frame_start got %b exp 1", frame_start); end
      for (int i = 0; i < 3 * 48; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL tiny_raster cyc=%0d got %h exp %h", cyc, a, e); end
         if (line_start) begin
            vecs++;
            if (lp !== 8) begin errs++; $display("FAIL tiny_line got %0d exp 8", lp); end
         end
         if (frame_start) begin
            vecs++;
            if (fp !== 48) begin errs++; $display("FAIL tiny_frame got %0d exp 48", fp); end
         end
         if (ev_hr) begin
            vecs++;
            if (hfx !== 5 || hlw !== 2) begin errs++; $display("FAIL tiny_hsync got start %0d width %0d exp 5 2", hfx, hlw); end
         end
      end
   endtask

   task automatic test_busy_write();
      vec_t e, a;
      bit   got = 0;
      tick(0, 0, 0, 1);
      e = exp_q.pop_front(); a = dut_vec(e); vecs++;
      if (a !== e) begin errs++; $display("FAIL busy_commit got %h exp %h", a, e); end
      tick(1, 0, 100, 0);
      e = exp_q.pop_front(); a = dut_vec(e); vecs++;
      if (a !== e) begin errs++; $display("FAIL busy_write got %h exp %h", a, e); end
      for (int i = 0; i < 2 * 48 + 4 && !got; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL busy_wait cyc=%0d got %h exp %h", cyc, a, e); end
         if (commit_done) got = 1;
      end
      vecs++;
      if (!got) begin errs++; $display("FAIL busy_commit_timeout got no commit_done exp pulse"); end
      for (int i = 0; i < 24; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL busy_after cyc=%0d got %h exp %h", cyc, a, e); end
         if (line_start) begin
            vecs++;
            if (lp !== 8) begin errs++; $display("FAIL busy_ignored_line got %0d exp 8", lp); end
         end
      end
   endtask

   task automatic test_zero_clamp_simul();
      vec_t e, a;
      tick(1, 1, 0, 0);
      e = exp_q.pop_front(); a = dut_vec(e); vecs++;
      if (a !== e) begin errs++; $display("FAIL zero_write got %h exp %h", a, e); end
      for (int i = 0; i < 100 && !(mx == hsum_m() - 1 && my == vsum_m() - 1); i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL seek_frame_end cyc=%0d got %h exp %h", cyc, a, e); end
      end
      tick(0, 0, 0, 1);
      e = exp_q.pop_front(); a = dut_vec(e); vecs++;
      if (a !== e) begin errs++; $display("FAIL simul_commit_vec got %h exp %h", a, e); end
      vecs++;
      if (commit_done !== 1'b1 || cfg_busy !== 1'b0) begin
         errs++; $display("FAIL simul_commit got done=%b busy=%b exp done=1 busy=0", commit_done, cfg_busy);
      end
      for (int i = 0; i < 48; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL clamp_raster cyc=%0d got %h exp %h", cyc, a, e); end
         if (line_start) begin
            vecs++;
            if (lp !== 8) begin errs++; $display("FAIL clamp_line got %0d exp 8", lp); end
         end
         if (ev_hr) begin
            vecs++;
            if (hfx !== 5) begin errs++; $display("FAIL clamp_fp_len got hsync start %0d exp 5", hfx); end
         end
      end
   endtask

   task automatic test_async_reset();
      vec_t e, a;
      bit   got = 0;
      rst = 1;
      repeat (2) @(negedge sys_clk);
      model_reset(); meas_reset(); rst = 0;
      for (int i = 0; i < 22; i++) begin
         if (i == 20)      tick(1, 0, 5, 0);
         else if (i == 21) tick(0, 0, 0, 1);
         else              tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL pre_reset cyc=%0d got %h exp %h", cyc, a, e); end
      end
      vecs++;
      if (cfg_busy !== 1'b1) begin errs++; $display("FAIL pending_before_reset got %b exp 1", cfg_busy); end
      #2 rst = 1;
      #1;
      model_reset();
      exp_q.push_back(model_vec());
      e = exp_q.pop_front(); a = dut_vec(e); vecs++;
      if (a !== e) begin errs++; $display("FAIL async_reset_state got %h exp %h", a, e); end
      @(negedge sys_clk);
      rst = 0; meas_reset();
      tick(0, 0, 0, 1);
      e = exp_q.pop_front(); a = dut_vec(e); vecs++;
      if (a !== e) begin errs++; $display("FAIL post_reset_commit got %h exp %h", a, e); end
      for (int i = 0; i < 2 * FRAME && !got; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL post_reset_wait cyc=%0d got %h exp %h", cyc, a, e); end
         if (commit_done) got = 1;
      end
      vecs++;
      if (!got) begin errs++; $display("FAIL post_reset_timeout got no commit_done exp pulse"); end
      for (int i = 0; i < 2 * LINE + 10; i++) begin
         tick(0, 0, 0, 0);
         e = exp_q.pop_front(); a = dut_vec(e); vecs++;
         if (a !== e) begin errs++; $display("FAIL default_resume cyc=%0d got %h exp %h", cyc, a, e); end
         if (line_start) begin
            vecs++;
            if (lp !== LINE) begin errs++; $display("FAIL default_after_reset got %0d exp %0d", lp, LINE); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_timing();
      test_blank_coords();
      test_reprogram();
      test_busy_write();
      test_zero_clamp_simul();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
